// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module : video_pkg
//  Brief  : Shared types, bar colour table and colour expansion helper for
//           the video test-pattern generator.
//  Rev    : 1.0  initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_mode_t;

    localparam int c_MAX_BPC = 32;

    // {R,G,B} on/off masks: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] c_BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    // Expands a 3-bit {R,G,B} mask to full-scale channels, packed in the low 3*bpc bits.
    function automatic logic [3*c_MAX_BPC-1:0] expand_rgb(input logic [2:0] mask, input int bpc);
        logic [3*c_MAX_BPC-1:0] res;
        res = '0;
        for (int i = 0; i < 3*c_MAX_BPC; i++) begin
            if (i < 3*bpc && ((mask >> (i / bpc)) & 3'b001) != 3'b000) begin
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_cnt.sv
`default_nettype none
// ============================================================================
//  Module : video_timing_cnt
//  Brief  : Raster h/v counters with enable hold, frame counter and
//           unregistered region decode (de/hsync/vsync/sof/eol).
//  Rev    : 1.0  initial release
// ============================================================================
module video_timing_cnt #(
    parameter int H_ACTIVE = 1366,
    parameter int H_FP     = 14,
    parameter int H_SYNC   = 56,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 28,
    localparam int c_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int c_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int c_H_W   = $clog2(c_H_TOT),
    localparam int c_V_W   = $clog2(c_V_TOT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [c_H_W-1:0] o_h,
    output logic [c_V_W-1:0] o_v,
    output logic [15:0]      o_frame_cnt,
    output logic             o_line_last,
    output logic             o_frame_last,
    output logic             o_de,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_sof,
    output logic             o_eol
);

    localparam logic [c_H_W-1:0] c_H_LAST = c_H_W'(c_H_TOT - 1);
    localparam logic [c_V_W-1:0] c_V_LAST = c_V_W'(c_V_TOT - 1);
    // One extra bit so a sync end equal to 2**width cannot alias to zero
    localparam logic [c_H_W:0]   c_H_ACT  = (c_H_W+1)'(H_ACTIVE);
    localparam logic [c_H_W:0]   c_HS_BEG = (c_H_W+1)'(H_ACTIVE + H_FP);
    localparam logic [c_H_W:0]   c_HS_END = (c_H_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_H_W:0]   c_H_EOL  = (c_H_W+1)'(H_ACTIVE - 1);
    localparam logic [c_V_W:0]   c_V_ACT  = (c_V_W+1)'(V_ACTIVE);
    localparam logic [c_V_W:0]   c_VS_BEG = (c_V_W+1)'(V_ACTIVE + V_FP);
    localparam logic [c_V_W:0]   c_VS_END = (c_V_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_H_W-1:0] r_h;
    logic [c_V_W-1:0] r_v;
    logic [15:0]      r_frame_cnt;
    logic [c_H_W:0]   w_hx;
    logic [c_V_W:0]   w_vx;

    assign o_line_last  = (r_h == c_H_LAST);
    assign o_frame_last = o_line_last && (r_v == c_V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else if (i_en) begin
            if (o_line_last) begin
                r_h <= '0;
                if (r_v == c_V_LAST) begin
                    r_v         <= '0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_v <= r_v + c_V_W'(1);
                end
            end else begin
                r_h <= r_h + c_H_W'(1);
            end
        end
    end

    assign w_hx = {1'b0, r_h};
    assign w_vx = {1'b0, r_v};

    assign o_h         = r_h;
    assign o_v         = r_v;
    assign o_frame_cnt = r_frame_cnt;
    assign o_de        = (w_hx < c_H_ACT) && (w_vx < c_V_ACT);
    assign o_hs        = (w_hx >= c_HS_BEG) && (w_hx < c_HS_END);
    assign o_vs        = (w_vx >= c_VS_BEG) && (w_vx < c_VS_END);
    assign o_sof       = (r_h == '0) && (r_v == '0);
    assign o_eol       = (w_hx == c_H_EOL) && (w_vx < c_V_ACT);

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module : video_pattern_gen
//  Brief  : Parametrised raster timing and runtime-selectable test pattern
//           source (bars, grey ramp, checker, solid) with registered outputs.
//  Rev    : 1.0  initial release
// ============================================================================
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int BPC      = 8,
    parameter int H_ACTIVE = 1366,
    parameter int H_FP     = 14,
    parameter int H_SYNC   = 56,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 28,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CHK_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [3*BPC-1:0] solid_i,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [3*BPC-1:0] data_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int c_H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_W   = $clog2(c_H_TOT);
    localparam int c_V_W   = $clog2(c_V_TOT);
    localparam int c_BAR_W = H_ACTIVE / 8;
    localparam int c_BC_W  = $clog2(c_BAR_W + 1);
    localparam logic [c_BC_W-1:0] c_BAR_LAST = c_BC_W'(c_BAR_W - 1);

    if (c_BAR_W < 1 || H_SYNC < 1 || V_SYNC < 1 || BPC < 1 || BPC > c_MAX_BPC) begin : g_param_check
        $error("video_pattern_gen: invalid parameter set");
    end

    logic [c_H_W-1:0] w_h;
    logic [c_V_W-1:0] w_v;
    logic             w_line_last;
    logic             w_frame_last;
    logic             w_de;
    logic             w_hs;
    logic             w_vs;
    logic             w_sof;
    logic             w_eol;

    video_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_en         (en_i),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_frame_cnt  (frame_cnt_o),
        .o_line_last  (w_line_last),
        .o_frame_last (w_frame_last),
        .o_de         (w_de),
        .o_hs         (w_hs),
        .o_vs         (w_vs),
        .o_sof        (w_sof),
        .o_eol        (w_eol)
    );

    // Mode/colour are captured at frame boundaries only; until the first enabled
    // cycle after reset the live inputs apply so frame 0 already uses them.
    pattern_mode_t    r_mode;
    logic [3*BPC-1:0] r_solid;
    logic             r_fresh;
    pattern_mode_t    w_mode;
    logic [3*BPC-1:0] w_solid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode  <= PAT_BARS;
            r_solid <= '0;
            r_fresh <= 1'b1;
        end else if (en_i && (r_fresh || w_frame_last)) begin
            r_mode  <= pattern_mode_t'(mode_i);
            r_solid <= solid_i;
            r_fresh <= 1'b0;
        end
    end

    assign w_mode  = r_fresh ? pattern_mode_t'(mode_i) : r_mode;
    assign w_solid = r_fresh ? solid_i : r_solid;

    // Bar index tracks the current h without a divider; bar 7 absorbs the remainder.
    logic [2:0]        r_bar_idx;
    logic [c_BC_W-1:0] r_bar_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bar_idx <= '0;
            r_bar_cnt <= '0;
        end else if (en_i) begin
            if (w_line_last) begin
                r_bar_idx <= '0;
                r_bar_cnt <= '0;
            end else if (r_bar_idx != 3'd7) begin
                if (r_bar_cnt == c_BAR_LAST) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                    r_bar_cnt <= '0;
                end else begin
                    r_bar_cnt <= r_bar_cnt + c_BC_W'(1);
                end
            end
        end
    end

    logic [3*BPC-1:0] w_bar_col [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_bar_col
        localparam logic [3*c_MAX_BPC-1:0] c_FULL = expand_rgb(c_BAR_RGB[gi], BPC);
        assign w_bar_col[gi] = c_FULL[3*BPC-1:0];
    end

    logic [BPC-1:0]   w_ramp;
    logic             w_chk_odd;
    logic [3*BPC-1:0] w_pix;

    assign w_ramp    = BPC'(w_h);
    assign w_chk_odd = 1'(w_h >> CHK_LOG2) ^ 1'(w_v >> CHK_LOG2);

    always_comb begin
        w_pix = '0;
        case (w_mode)
            PAT_BARS:  w_pix = w_bar_col[r_bar_idx];
            PAT_RAMP:  w_pix = {3{w_ramp}};
            PAT_CHECK: w_pix = w_chk_odd ? '0 : '1;
            PAT_SOLID: w_pix = w_solid;
            default:   w_pix = '0;
        endcase
    end

    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic             r_sof;
    logic             r_eol;
    logic [3*BPC-1:0] r_data;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_de   <= 1'b0;
            r_sof  <= 1'b0;
            r_eol  <= 1'b0;
            r_data <= '0;
            r_hs   <= ~HS_POL;
            r_vs   <= ~VS_POL;
        end else begin
            r_de   <= w_de;
            r_sof  <= w_sof;
            r_eol  <= w_eol;
            r_data <= w_de ? w_pix : '0;
            r_hs   <= w_hs ? HS_POL : ~HS_POL;
            r_vs   <= w_vs ? VS_POL : ~VS_POL;
        end
    end

    assign de_o    = r_de;
    assign hsync_o = r_hs;
    assign vsync_o = r_vs;
    assign sof_o   = r_sof;
    assign eol_o   = r_eol;
    assign data_o  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module : tb_video_pattern_gen
//  Brief  : Self-checking bench for video_pattern_gen on a small raster
//           (H 16/2/3/3, V 4/1/2/1) with a frame-position reference model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_video_pattern_gen;

    localparam int BPC   = 8;
    localparam int H_ACT = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACT = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int CHK   = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int BAR_W = H_ACT / 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [23:0] solid_i = 24'h0;
    logic        de_o, hsync_o, vsync_o, sof_o, eol_o;
    logic [23:0] data_o;
    logic [15:0] frame_cnt_o;

    video_pattern_gen #(
        .BPC(BPC), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(CHK)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .solid_i(solid_i),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .data_o(data_o),
        .sof_o(sof_o), .eol_o(eol_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: linear position within the frame plus the mode owned by the frame.
    function automatic logic [23:0] ref_pixel(int h, int v, logic [1:0] md, logic [23:0] sd);
        int bar;
        case (md)
            2'd0: begin
                bar = h / BAR_W;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: return {3{8'(h % 256)}};
            2'd2: return ((((h >> CHK) ^ (v >> CHK)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return sd;
        endcase
    endfunction

    int          m_pos = 0;
    int          m_fc = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [23:0] m_solid = 24'h0;
    bit          m_fresh = 1'b1;
    logic        e_de, e_hs, e_vs, e_sof, e_eol;
    logic [23:0] e_data;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_pos <= 0; m_fc <= 0; m_mode <= 2'd0; m_solid <= 24'h0; m_fresh <= 1'b1;
            e_de <= 0; e_hs <= 0; e_vs <= 0; e_sof <= 0; e_eol <= 0; e_data <= 24'h0;
        end else if (!en_i) begin
            e_de <= 0; e_hs <= 0; e_vs <= 0; e_sof <= 0; e_eol <= 0; e_data <= 24'h0;
        end else begin
            e_de   <= (m_pos % H_TOT < H_ACT) && (m_pos / H_TOT < V_ACT);
            e_data <= ((m_pos % H_TOT < H_ACT) && (m_pos / H_TOT < V_ACT))
                      ? ref_pixel(m_pos % H_TOT, m_pos / H_TOT, m_fresh ? mode_i : m_mode,
                                  m_fresh ? solid_i : m_solid)
                      : 24'h0;
            e_hs   <= (m_pos % H_TOT >= H_ACT + H_FP) && (m_pos % H_TOT < H_ACT + H_FP + H_SYNC);
            e_vs   <= (m_pos / H_TOT >= V_ACT + V_FP) && (m_pos / H_TOT < V_ACT + V_FP + V_SYNC);
            e_sof  <= (m_pos == 0);
            e_eol  <= (m_pos % H_TOT == H_ACT - 1) && (m_pos / H_TOT < V_ACT);
            if (m_fresh || m_pos == FRAME - 1) begin
                m_mode  <= mode_i;
                m_solid <= solid_i;
            end
            m_fresh <= 1'b0;
            if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                m_fc  <= (m_fc + 1) % 65536;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    // Leaves the bench on a negedge with reset just released; next edge is the first enabled one.
    task automatic do_reset(input logic [1:0] md, input logic [23:0] sd);
        @(negedge clk_i);
        rst_i = 1'b1; en_i = 1'b1; mode_i = md; solid_i = sd;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2'd0, 24'h0);
        repeat (200) @(negedge clk_i);
        n_cmp++;
        if (frame_cnt_o !== 16'd1) begin n_bad++; $display("FAIL reset_pre_fc: got %0d want 1", frame_cnt_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (de_o !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %b want 0", de_o); end
        n_cmp++;
        if (hsync_o !== 1'b0 || vsync_o !== 1'b0) begin n_bad++; $display("FAIL reset_sync: got hs=%b vs=%b want 0 0", hsync_o, vsync_o); end
        n_cmp++;
        if (data_o !== 24'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000000", data_o); end
        n_cmp++;
        if (sof_o !== 1'b0 || eol_o !== 1'b0) begin n_bad++; $display("FAIL reset_sof_eol: got %b%b want 00", sof_o, eol_o); end
        n_cmp++;
        if (frame_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_fc: got %0d want 0", frame_cnt_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_bars();
        do_reset(2'd0, 24'h0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                n_cmp++;
                if ({de_o, sof_o, data_o} !== {2'b11, 24'hFFFFFF}) begin
                    n_bad++; $display("FAIL bars_first: got de=%b sof=%b data=%h want 1 1 FFFFFF", de_o, sof_o, data_o);
                end
            end
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (data_o !== 24'hFFFF00) begin n_bad++; $display("FAIL bars_yellow px%0d: got %h want FFFF00", c, data_o); end
            end
            if (c == 14 || c == 15) begin
                n_cmp++;
                if ({de_o, data_o} !== {1'b1, 24'h000000}) begin
                    n_bad++; $display("FAIL bars_black px%0d: got de=%b data=%h want 1 000000", c, de_o, data_o);
                end
            end
            n_cmp++;
            if (eol_o !== (c == 15)) begin n_bad++; $display("FAIL bars_eol px%0d: got %b want %b", c, eol_o, (c == 15)); end
        end
    endtask

    task automatic test_free_run();
        int de_cnt[2], hs_cnt[2], vs_cnt[2];
        int hs_pos_err, fc1_at, fc2_at, f, h;
        hs_pos_err = 0; fc1_at = -1; fc2_at = -1;
        for (int i = 0; i < 2; i++) begin de_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0; end
        do_reset(2'd0, 24'h0);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk_i);
            f = c / FRAME;
            h = c % H_TOT;
            if (de_o === 1'b1) de_cnt[f]++;
            if (hsync_o === 1'b1) hs_cnt[f]++;
            if (vsync_o === 1'b1) vs_cnt[f]++;
            if (hsync_o !== (h >= 18 && h <= 20)) hs_pos_err++;
            if (frame_cnt_o === 16'd1 && fc1_at < 0) fc1_at = c;
            if (frame_cnt_o === 16'd2 && fc2_at < 0) fc2_at = c;
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (de_cnt[i] != 64) begin n_bad++; $display("FAIL run_de_count f%0d: got %0d want 64", i, de_cnt[i]); end
            n_cmp++;
            if (hs_cnt[i] != 24) begin n_bad++; $display("FAIL run_hs_count f%0d: got %0d want 24", i, hs_cnt[i]); end
            n_cmp++;
            if (vs_cnt[i] != 48) begin n_bad++; $display("FAIL run_vs_count f%0d: got %0d want 48", i, vs_cnt[i]); end
        end
        n_cmp++;
        if (hs_pos_err != 0) begin n_bad++; $display("FAIL run_hs_pos: got %0d misplaced want 0", hs_pos_err); end
        n_cmp++;
        if (fc1_at != FRAME - 1 || fc2_at != 2 * FRAME - 1) begin
            n_bad++; $display("FAIL run_fc_period: got %0d,%0d want %0d,%0d", fc1_at, fc2_at, FRAME - 1, 2 * FRAME - 1);
        end
    endtask

    task automatic test_solid();
        int bad0, bad1;
        bad0 = 0; bad1 = 0;
        do_reset(2'd3, 24'h123456);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk_i);
            if (de_o === 1'b1) begin
                if (c < FRAME && data_o !== 24'h123456) bad0++;
                if (c >= FRAME && data_o !== 24'hABCDEF) bad1++;
            end
            if (c == 73) begin
                n_cmp++;
                if (data_o !== 24'h123456) begin n_bad++; $display("FAIL solid_mid: got %h want 123456", data_o); end
            end
            if (c == FRAME) begin
                n_cmp++;
                if (data_o !== 24'hABCDEF) begin n_bad++; $display("FAIL solid_next: got %h want ABCDEF", data_o); end
            end
            if (c == 50) solid_i = 24'hABCDEF;
        end
        n_cmp++;
        if (bad0 != 0 || bad1 != 0) begin n_bad++; $display("FAIL solid_frames: got %0d/%0d wrong pixels want 0/0", bad0, bad1); end
    endtask

    task automatic test_pause();
        int idle_bad, sof2_at, fc1_at;
        idle_bad = 0; sof2_at = -1; fc1_at = -1;
        do_reset(2'd0, 24'h0);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            @(negedge clk_i);
            if (c >= 31 && c <= 35 && {de_o, sof_o, eol_o, hsync_o, vsync_o, data_o} !== 29'h0) idle_bad++;
            if (c == 30 || c == 36) begin
                n_cmp++;
                if ({de_o, data_o} !== {1'b1, 24'h00FF00}) begin
                    n_bad++; $display("FAIL pause_px7 c%0d: got de=%b data=%h want 1 00FF00", c, de_o, data_o);
                end
            end
            if (c == 37) begin
                n_cmp++;
                if (data_o !== 24'hFF00FF) begin n_bad++; $display("FAIL pause_px8: got %h want FF00FF", data_o); end
            end
            if (c > 0 && sof_o === 1'b1 && sof2_at < 0) sof2_at = c;
            if (frame_cnt_o === 16'd1 && fc1_at < 0) fc1_at = c;
            if (c == 30) en_i = 1'b0;
            if (c == 35) en_i = 1'b1;
        end
        n_cmp++;
        if (idle_bad != 0) begin n_bad++; $display("FAIL pause_idle: got %0d active cycles want 0", idle_bad); end
        n_cmp++;
        if (sof2_at != FRAME + 5 || fc1_at != FRAME + 4) begin
            n_bad++; $display("FAIL pause_frame_len: got sof@%0d fc@%0d want %0d %0d", sof2_at, fc1_at, FRAME + 5, FRAME + 4);
        end
    endtask

    task automatic test_checker_ramp();
        do_reset(2'd2, 24'h0);
        for (int c = 0; c <= FRAME + 9; c++) begin
            @(negedge clk_i);
            if (c == 0 || c == 1 || c == 8 || c == 12) begin
                n_cmp++;
                if (data_o !== 24'hFFFFFF) begin n_bad++; $display("FAIL chk_white c%0d: got %h want FFFFFF", c, data_o); end
            end
            if (c == 2 || c == 3 || c == 48 || c == 49) begin
                n_cmp++;
                if ({de_o, data_o} !== {1'b1, 24'h000000}) begin
                    n_bad++; $display("FAIL chk_black c%0d: got de=%b data=%h want 1 000000", c, de_o, data_o);
                end
            end
            if (c == FRAME + 9) begin
                n_cmp++;
                if (data_o !== 24'h090909) begin n_bad++; $display("FAIL ramp_px9: got %h want 090909", data_o); end
            end
            if (c == 10) mode_i = 2'd1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd0, 24'h0);
        for (int c = 0; c < FRAME + 60; c++) begin
            @(negedge clk_i);
            if (c == FRAME + 57) begin
                n_cmp++;
                if (frame_cnt_o !== 16'd1) begin n_bad++; $display("FAIL rstmid_pre_fc: got %0d want 1", frame_cnt_o); end
                rst_i = 1'b1;
            end
            if (c == FRAME + 58) begin
                n_cmp++;
                if ({de_o, hsync_o, vsync_o, sof_o, eol_o, data_o, frame_cnt_o} !== 45'h0) begin
                    n_bad++;
                    $display("FAIL rstmid_outputs: got de=%b hs=%b vs=%b sof=%b eol=%b data=%h fc=%0d want all 0",
                             de_o, hsync_o, vsync_o, sof_o, eol_o, data_o, frame_cnt_o);
                end
                rst_i = 1'b0;
            end
            if (c == FRAME + 59) begin
                n_cmp++;
                if ({de_o, sof_o, data_o} !== {2'b11, 24'hFFFFFF}) begin
                    n_bad++; $display("FAIL rstmid_restart: got de=%b sof=%b data=%h want 1 1 FFFFFF", de_o, sof_o, data_o);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)), 24'($urandom));
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            n_cmp++;
            if ({de_o, hsync_o, vsync_o, sof_o, eol_o, data_o, frame_cnt_o} !==
                {e_de, e_hs, e_vs, e_sof, e_eol, e_data, 16'(m_fc)}) begin
                n_bad++;
                $display("FAIL random c%0d: got de=%b hs=%b vs=%b sof=%b eol=%b data=%h fc=%0d want %b %b %b %b %b %h %0d",
                         c, de_o, hsync_o, vsync_o, sof_o, eol_o, data_o, frame_cnt_o,
                         e_de, e_hs, e_vs, e_sof, e_eol, e_data, m_fc);
            end
            rst_i = ($urandom_range(0, 999) == 0);
            en_i  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) solid_i = 24'($urandom);
        end
        rst_i = 1'b0;
        en_i  = 1'b1;
    endtask

    initial begin
        test_reset();
        test_bars();
        test_free_run();
        test_solid();
        test_pause();
        test_checker_ramp();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
